pio_byte_cmd_engine: RTL
========================

Name: pio_byte_cmd_engine

Overview:
- Sits directly downstream of the 9-bit Avalon PIO output port; consumes its out_port word as a byte-serial command channel from the Nios CPU.
- Bit 8 is a toggle strobe and bits 7:0 are a data byte.
- Assembles bytes into write/read frames and issues single-byte Avalon-MM master transfers into the edited memory.
- Returns read data and a completion toggle on a status word that feeds an input PIO.

Parameters:
- ADDR_BYTES, 2, number of address bytes per frame (1..4), MSB first
- ADDR_W, 16, width of mem_address; must be <= 8*ADDR_BYTES, upper assembled bits are discarded
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, same domain as the PIO
- reset  input  1  asynchronous, active-high reset
- pio_in  input  9  PIO out_port word: [8] strobe toggle, [7:0] byte
- mem_address  output  ADDR_W  Avalon-MM master address
- mem_write  output  1  write request
- mem_read  output  1  read request
- mem_writedata  output  8  write data
- mem_readdata  input  8  read data, valid when mem_read and !mem_waitrequest
- mem_waitrequest  input  1  slave stall
- status_out  output  12  {busy, overrun, err, ack_tog, rdata[7:0]} to input PIO

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. On reset all outputs are 0, the FSM enters IDLE, and tog_q=0 (matches the PIO's reset value of 0).
- Byte accept: a byte is accepted on any edge where pio_in[8] != tog_q. On that edge tog_q <= pio_in[8] and byte <= pio_in[7:0]. At most one byte is accepted per toggle; a static pio_in never produces a byte.
- Frame format: opcode, then ADDR_BYTES address bytes, then one data byte (write only). Opcode 0x01 = write, 0x02 = read.
- IDLE: on accept, a valid opcode latches the op, clears err and overrun, clears the byte count, and moves to ADDR. Any other opcode sets err (sticky until the next valid opcode) and stays in IDLE.
- ADDR: each accepted byte does addr <= {addr[8*ADDR_BYTES-9:0], byte}. After ADDR_BYTES bytes, go to DATA for a write or REQ for a read.
- DATA: the accepted byte goes to mem_writedata; go to REQ.
- REQ: mem_write or mem_read is asserted starting the cycle after the last byte is accepted. mem_address, mem_writedata and the request stay stable while mem_waitrequest=1. The transfer completes on the first cycle with mem_waitrequest=0; on that edge, a read captures mem_readdata into rdata. Go to DONE. Request is deasserted the cycle after completion.
- DONE: for one cycle, ack_tog flips, then return to IDLE.
- Latency with waitrequest=0: the request is high exactly one cycle, and ack_tog flips 2 cycles after the final byte is accepted.
- busy = 1 in every state except IDLE.
- Overrun: a byte accepted while in REQ or DONE is dropped, sets overrun (sticky until the next valid opcode), and tog_q still updates.
- Simultaneous events: a toggle on the same edge as the REQ completion counts as overrun.
- Address wrap: only the low ADDR_W bits drive mem_address; there is no address increment.
- Reset mid-frame or mid-request aborts immediately and deasserts the request asynchronously.

Optional Feature:
- Macro: PIO_CMD_TIMEOUT_EN.
- When defined: a counter clears on every accepted byte and counts while in ADDR or DATA. Reaching TIMEOUT_CYCLES-1 aborts the partial frame to IDLE and sets err. The abort applies only in ADDR/DATA; REQ is never aborted.
- When undefined: there is no counter, and a partial frame waits indefinitely.

Test Plan:
- Write frame: toggles carrying 0x01, 0x12, 0x34, 0xAB with waitrequest=0 -> one cycle mem_write=1, address 0x1234, writedata 0xAB; ack_tog 0->1; busy back to 0.
- Read with stall: memory[0x0005]=0x5A; send 0x02, 0x00, 0x05; waitrequest high 3 cycles -> mem_read held 4 cycles with the address stable; rdata=0x5A; ack_tog toggles.
- Bad opcode: send 0x07 -> err=1, no memory access; then send a valid read frame -> err=0.
- Overrun: send a byte toggle while waitrequest holds REQ -> overrun=1, the in-flight transfer completes, and the next frame is parsed correctly.
- Reset mid-frame: assert reset after 0x01, 0x12 -> outputs 0; after release, a full write frame executes correctly.
- Timeout (PIO_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16): send 0x01, 0x12, then idle 20 cycles -> IDLE with err=1; the next 0x01 frame executes correctly.

Source files
------------

// File: rtl/pio_byte_cmd_engine_if.sv
// Avalon-MM single-byte master bus used by pio_byte_cmd_engine.
// master: the command engine; slave: the edited memory.
interface pio_byte_cmd_engine_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic              mem_read;
  logic [7:0]        mem_writedata;
  logic [7:0]        mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address,
    output mem_write,
    output mem_read,
    output mem_writedata,
    input  mem_readdata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_address,
    input  mem_write,
    input  mem_read,
    input  mem_writedata,
    output mem_readdata,
    output mem_waitrequest
  );
endinterface

// File: rtl/pio_byte_cmd_engine.sv
// Byte-serial command engine fed by a 9-bit PIO out_port ([8] strobe toggle, [7:0] byte).
// Frames: opcode (0x01 write / 0x02 read), ADDR_BYTES address bytes MSB first, then one
// data byte for writes. Each frame issues one single-byte Avalon-MM transfer; completion is
// reported by flipping ack_tog in status_out = {busy, overrun, err, ack_tog, rdata}.
// Optional build macro PIO_CMD_TIMEOUT_EN: abort a partial frame after TIMEOUT_CYCLES idle
// cycles in ADDR/DATA and flag err.
module pio_byte_cmd_engine #(
  parameter int unsigned ADDR_BYTES     = 2,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            pio_in,
  pio_byte_cmd_engine_if.master mem,
  output logic [11:0]           status_out
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned CW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam logic [7:0]    OpWrite     = 8'h01;
  localparam logic [7:0]    OpRead      = 8'h02;
  localparam logic [CW-1:0] LastAddrIdx = CW'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StReq, StDone} state_e;

  state_e        state_q, state_d;
  logic          tog_q;
  logic          accept;
  logic [7:0]    rx_byte;
  logic          op_write_q, op_write_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          ack_q, ack_d;
  logic          timeout;

  // A new byte is present whenever the strobe bit differs from the last one seen.
  assign accept  = (pio_in[8] != tog_q);
  assign rx_byte = pio_in[7:0];

`ifdef PIO_CMD_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_q;
  logic          to_run;

  assign to_run  = (state_q == StAddr) || (state_q == StData);
  assign timeout = to_run && (to_q == ToLast);

  // Inter-byte timer: restarts on every byte, only runs inside a partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_q <= '0;
    end else if (accept || !to_run) begin
      to_q <= '0;
    end else if (!timeout) begin
      to_q <= to_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Track the strobe bit so each toggle is consumed exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= pio_in[8];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      ack_q      <= ack_d;
    end
  end

  // Frame parser and transfer sequencing.
  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ovr_d      = ovr_q;
    ack_d      = ack_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if ((rx_byte == OpWrite) || (rx_byte == OpRead)) begin
            op_write_d = (rx_byte == OpWrite);
            err_d      = 1'b0;
            ovr_d      = 1'b0;
            cnt_d      = '0;
            state_d    = StAddr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d = (addr_q << 8) | AW'(rx_byte);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LastAddrIdx) begin
            state_d = op_write_q ? StData : StReq;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StData: begin
        if (accept) begin
          wdata_d = rx_byte;
          state_d = StReq;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StReq: begin
        // Bytes arriving while a transfer is outstanding are dropped.
        if (accept) begin
          ovr_d = 1'b1;
        end
        if (!mem.mem_waitrequest) begin
          if (!op_write_q) begin
            rdata_d = mem.mem_readdata;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (accept) begin
          ovr_d = 1'b1;
        end
        ack_d   = ~ack_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Request is decoded from state so reset drops it asynchronously.
  assign mem.mem_address   = addr_q[ADDR_W-1:0];
  assign mem.mem_writedata = wdata_q;
  assign mem.mem_write     = (state_q == StReq) && op_write_q;
  assign mem.mem_read      = (state_q == StReq) && !op_write_q;

  assign status_out = {(state_q != StIdle), ovr_q, err_q, ack_q, rdata_q};

endmodule
